// File: rtl/wb_csr_bridge.sv
// Wishbone slave to CSR bus bridge: one 32-bit CSR word per address, fixed
// single-cycle write strobe and two-cycle registered read path.
module wb_csr_bridge (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [13:0] csr_a,
  output logic        csr_we,
  output logic [31:0] csr_do,
  input  logic [31:0] csr_di
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD1,
    S_RD2,
    S_ACKED
  } state_t;

  state_t      r_state;
  logic [13:0] r_csrA;
  logic        r_csrWe;
  logic [31:0] r_csrDo;
  logic [31:0] r_datO;
  logic        r_ack;

  logic        w_req;
  logic        w_unusedAdr;

  assign w_req       = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_unusedAdr = ^{wb_adr_i[31:16], wb_adr_i[1:0]};

  // Responders register csr_di one cycle after seeing csr_a, so reads spend
  // RD1 holding the address and capture the returned word on leaving RD2.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_csrA  <= '0;
      r_csrWe <= 1'b0;
      r_csrDo <= '0;
      r_datO  <= '0;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_csrA  <= wb_adr_i[15:2];
            r_csrDo <= wb_dat_i;
            r_csrWe <= wb_we_i;
            r_state <= wb_we_i ? S_WR : S_RD1;
          end
        end
        S_WR: begin
          r_csrWe <= 1'b0;
          r_ack   <= wb_cyc_i;
          r_state <= wb_cyc_i ? S_ACKED : S_IDLE;
        end
        S_RD1: begin
          r_state <= S_RD2;
        end
        S_RD2: begin
          // A dropped cycle still captures the data, it just goes unacknowledged.
          r_datO  <= csr_di;
          r_ack   <= wb_cyc_i;
          r_state <= wb_cyc_i ? S_ACKED : S_IDLE;
        end
        S_ACKED: begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_csrWe <= 1'b0;
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign csr_a    = r_csrA;
  assign csr_we   = r_csrWe;
  assign csr_do   = r_csrDo;
  assign wb_dat_o = r_datO;
  assign wb_ack_o = r_ack;

endmodule

// File: tb/tb_wb_csr_bridge.sv
// Directed bench for wb_csr_bridge: a transaction-timeline model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_wb_csr_bridge;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic        wb_ack_o;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_do;
  logic [31:0] csr_di = '0;

  int vectors = 0;
  int miscompares = 0;
  logic checkEn = 1'b0;

  wb_csr_bridge dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_we_i (wb_we_i),
    .wb_ack_o(wb_ack_o),
    .csr_a   (csr_a),
    .csr_we  (csr_we),
    .csr_do  (csr_do),
    .csr_di  (csr_di)
  );

  always #5 sys_clk = ~sys_clk;

  // Responder at CSR block 0 with 16 registers and a registered read port.
  logic [31:0] respMem [16];
  initial for (int i = 0; i < 16; i++) respMem[i] = '0;

  always @(posedge sys_clk) begin
    if (csr_we && csr_a[13:10] == 4'd0) respMem[csr_a[3:0]] <= csr_do;
    csr_di <= (csr_a[13:10] == 4'd0) ? respMem[csr_a[3:0]] : 32'h0;
  end

  // Timeline model: an accepted transaction completes one edge later for a
  // write and two edges later for a read; the bus is free again one edge after
  // completion if it was aborted, two if it was acknowledged.
  int          mEdge;
  int          mComp;
  int          mFree;
  logic        mIsRead;
  logic [13:0] mA;
  logic [31:0] mDo;
  logic        mWe;
  logic [31:0] mDat;
  logic        mAck;
  logic [31:0] mExp;
  logic [31:0] mMem [16];
  initial for (int i = 0; i < 16; i++) mMem[i] = '0;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mEdge = 0; mComp = -1; mFree = 0; mIsRead = 1'b0;
      mA = '0; mDo = '0; mWe = 1'b0; mDat = '0; mAck = 1'b0; mExp = '0;
    end else begin
      mEdge = mEdge + 1;
      mAck = 1'b0;
      mWe = 1'b0;
      if (mEdge == mComp) begin
        if (mIsRead) mDat = mExp;
        else if (mA[13:10] == 4'd0) mMem[mA[3:0]] = mDo;
        mAck = wb_cyc_i;
        mFree = wb_cyc_i ? mEdge + 2 : mEdge + 1;
        mComp = -1;
      end else if (mEdge >= mFree && wb_cyc_i && wb_stb_i) begin
        mA = wb_adr_i[15:2];
        mDo = wb_dat_i;
        mWe = wb_we_i;
        mIsRead = !wb_we_i;
        mComp = wb_we_i ? mEdge + 1 : mEdge + 2;
        mFree = 32'h7fff_ffff;
        mExp = (mA[13:10] == 4'd0) ? mMem[mA[3:0]] : 32'h0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    if (checkEn) begin
      checkOutput("model ack", {31'b0, wb_ack_o}, {31'b0, mAck});
      checkOutput("model csr_we", {31'b0, csr_we}, {31'b0, mWe});
      checkOutput("model csr_a", {18'b0, csr_a}, {18'b0, mA});
      checkOutput("model csr_do", csr_do, mDo);
      checkOutput("model dat_o", wb_dat_o, mDat);
    end
  end

  // One Wishbone transaction; abortAt drops the cycle at that negedge count.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input int abortAt, output int ackAt, output logic [31:0] rdata,
                               output int weCycles);
    @(negedge sys_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    ackAt = -1; rdata = '0; weCycles = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge sys_clk);
      if (csr_we) weCycles = weCycles + 1;
      if (wb_ack_o && ackAt < 0) begin
        ackAt = n; rdata = wb_dat_o; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
      if (n == abortAt) begin
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  initial begin
    int ackAt, ack1At, ack2At, weCycles, ackCount;
    logic [31:0] rdata;

    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    checkEn = 1'b1;
    checkOutput("reset ack", {31'b0, wb_ack_o}, 32'h0);
    checkOutput("reset dat_o", wb_dat_o, 32'h0);

    applyStimulus(1'b1, 32'h0000_0004, 32'h0000_0500, 0, ackAt, rdata, weCycles);
    checkOutput("write ack latency", ackAt, 32'd2);
    checkOutput("write strobe cycles", weCycles, 32'd1);
    checkOutput("write csr_a", {18'b0, csr_a}, 32'h001);
    checkOutput("write csr_do", csr_do, 32'h500);
    checkOutput("responder reg1", respMem[1], 32'h500);

    applyStimulus(1'b0, 32'h0000_0004, 32'h0, 0, ackAt, rdata, weCycles);
    checkOutput("read ack latency", ackAt, 32'd3);
    checkOutput("read data", rdata, 32'h500);
    checkOutput("read strobe cycles", weCycles, 32'd0);

    // Back-to-back with strobe held: switch to the read during the write's ack cycle.
    @(negedge sys_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h24; wb_dat_i = 32'hDEAD_BEEF;
    ack1At = -1; ack2At = -1; rdata = '0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge sys_clk);
      if (wb_ack_o) begin
        if (ack1At < 0) ack1At = n;
        else if (ack2At < 0) begin
          ack2At = n; rdata = wb_dat_o; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        end
      end
      if (n == 2) begin wb_we_i = 1'b0; wb_dat_i = '0; end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    checkOutput("b2b first ack", ack1At, 32'd2);
    checkOutput("b2b second ack", ack2At, 32'd6);
    checkOutput("b2b read data", rdata, 32'hDEAD_BEEF);

    applyStimulus(1'b0, 32'h0000_0028, 32'h0, 2, ackAt, rdata, weCycles);
    checkOutput("abort rd2 no ack", ackAt, 32'hFFFF_FFFF);
    checkOutput("abort rd2 captured", wb_dat_o, 32'h0);

    applyStimulus(1'b1, 32'h0000_0008, 32'h1234_5678, 0, ackAt, rdata, weCycles);
    checkOutput("post-abort write ack", ackAt, 32'd2);
    checkOutput("dat_o held over write", wb_dat_o, 32'h0);

    applyStimulus(1'b0, 32'h0000_0024, 32'h0, 1, ackAt, rdata, weCycles);
    checkOutput("abort rd1 no ack", ackAt, 32'hFFFF_FFFF);
    checkOutput("abort rd1 captured", wb_dat_o, 32'hDEAD_BEEF);

    // Asynchronous reset in the middle of the WR cycle.
    @(negedge sys_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h0C; wb_dat_i = 32'hCAFE_F00D;
    @(posedge sys_clk);
    #2;
    sys_rst = 1'b1;
    #1;
    checkOutput("reset-in-WR csr_we", {31'b0, csr_we}, 32'h0);
    checkOutput("reset-in-WR ack", {31'b0, wb_ack_o}, 32'h0);
    checkOutput("reset-in-WR csr_a", {18'b0, csr_a}, 32'h0);
    checkOutput("reset-in-WR csr_do", csr_do, 32'h0);
    checkOutput("reset-in-WR dat_o", wb_dat_o, 32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    ackCount = 0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge sys_clk);
      if (wb_ack_o) ackCount = ackCount + 1;
    end
    checkOutput("no ack after reset", ackCount, 32'd0);

    // Request already pending when reset releases is taken on the first edge.
    @(negedge sys_clk);
    sys_rst = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h10; wb_dat_i = 32'h0000_00A5;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    ackAt = -1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge sys_clk);
      if (wb_ack_o && ackAt < 0) begin
        ackAt = n; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    checkOutput("first edge accept", ackAt, 32'd2);

    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 0, ackAt, rdata, weCycles);
    checkOutput("read after reset", rdata, 32'h0000_00A5);
    applyStimulus(1'b0, 32'h0000_000C, 32'h0, 0, ackAt, rdata, weCycles);
    checkOutput("reset-killed write", rdata, 32'h0);

    applyStimulus(1'b0, 32'hFFFF_0407, 32'h0, 0, ackAt, rdata, weCycles);
    checkOutput("masked csr_a", {18'b0, csr_a}, 32'h101);
    checkOutput("masked read data", rdata, 32'h500);
    checkOutput("masked ack latency", ackAt, 32'd3);

    applyStimulus(1'b0, 32'h0000_1004, 32'h0, 0, ackAt, rdata, weCycles);
    checkOutput("block1 csr_a", {18'b0, csr_a}, 32'h401);
    checkOutput("block1 read data", rdata, 32'h0);

    repeat (2) @(negedge sys_clk);
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_csr_bridge.md
WB_CSR_BRIDGE -- requirements
Module: wb_csr_bridge

Interface
REQ-001 The block SHALL have no parameters; the CSR address is always wb_adr_i[15:2], giving one 32-bit word per CSR address.
REQ-002 sys_clk  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 sys_rst  in  1  reset, asynchronous, active-high.
REQ-004 wb_adr_i  in  32  Wishbone byte address; only bits [15:2] SHALL be used.
REQ-005 wb_dat_i  in  32  Wishbone write data.
REQ-006 wb_dat_o  out  32  Wishbone read data, registered.
REQ-007 wb_cyc_i  in  1  Wishbone bus cycle.
REQ-008 wb_stb_i  in  1  Wishbone strobe.
REQ-009 wb_we_i  in  1  Wishbone write enable.
REQ-010 wb_ack_o  out  1  Wishbone acknowledge, registered, one-cycle pulse.
REQ-011 csr_a  out  14  CSR address to all responders; bits [13:10] select the responder, bits [3:0] select the register.
REQ-012 csr_we  out  1  CSR write strobe.
REQ-013 csr_do  out  32  CSR write data to the responders.
REQ-014 csr_di  in  32  OR of all responder read outputs; a responder drives its value one cycle after it samples csr_a.

Function
REQ-015 The FSM SHALL have five states:
- IDLE
- WR (write issue)
- RD1 (read address)
- RD2 (read capture)
- ACKED
REQ-016 In IDLE, a request SHALL be accepted when wb_cyc_i & wb_stb_i & ~wb_ack_o is sampled high.
REQ-017 On acceptance, at the same edge:
- csr_a <= wb_adr_i[15:2]
- csr_do <= wb_dat_i
- csr_we <= wb_we_i
- state <= WR if wb_we_i, else RD1
REQ-018 WR: csr_we SHALL be high for exactly this one cycle; at the exit edge csr_we <= 0, wb_ack_o <= 1 and state <= ACKED.
REQ-019 RD1: csr_we SHALL be low, and csr_a SHALL be held so the responder registers its data; at the exit edge state <= RD2.
REQ-020 RD2: at the exit edge wb_dat_o <= csr_di, wb_ack_o <= 1 and state <= ACKED.
REQ-021 ACKED: wb_ack_o SHALL be high for exactly this one cycle; at the exit edge wb_ack_o <= 0 and state <= IDLE.
REQ-022 No request SHALL be accepted in ACKED.
REQ-023 Latency, counted from the acceptance edge to wb_ack_o high:
- write: 2 cycles
- read: 3 cycles
- minimum spacing between acceptances: write 3 cycles, read 4 cycles
REQ-024 csr_a and csr_do SHALL hold their last values between transactions.
REQ-025 csr_we SHALL be high only in WR.
REQ-026 wb_dat_o SHALL change only at the RD2 exit edge and SHALL hold its value otherwise, including across writes.
REQ-027 Abort: if wb_cyc_i is low at the WR or RD2 exit edge:
- the CSR side completes unchanged (the write strobe is already issued);
- wb_ack_o SHALL stay 0;
- state <= IDLE directly, skipping ACKED;
- in RD2, wb_dat_o SHALL still capture csr_di.
REQ-028 wb_cyc_i low in RD1 SHALL NOT alter RD1; the abort rule applies at the following RD2 exit edge.
REQ-029 wb_stb_i changes after acceptance SHALL be ignored until the FSM returns to IDLE.
REQ-030 wb_adr_i bits [31:16] and [1:0] SHALL NOT affect behaviour.

Reset
REQ-031 While sys_rst is high, independent of sys_clk:
- state = IDLE
- csr_a = 0, csr_we = 0, csr_do = 0
- wb_dat_o = 0, wb_ack_o = 0
REQ-032 Reset mid-transaction SHALL immediately drop csr_we and wb_ack_o, and SHALL NOT produce any later ack for that transaction.
REQ-033 After sys_rst deasserts, the first edge SHALL be able to accept a request.

Verification
REQ-034 Write: adr=0x0000_0004, dat=0x0000_0500, we=1, with a responder at CSR block 0 -> csr_a=0x001 and csr_we=1 for exactly one cycle, csr_do=0x500; ack 2 cycles after acceptance; responder register 1 reads 0x500.
REQ-035 Read: adr=0x0000_0004 after REQ-034 -> csr_we stays 0; ack 3 cycles after acceptance; wb_dat_o=0x0000_0500 in the ack cycle.
REQ-036 Back-to-back: stb held high across write 0x24=0xDEADBEEF then read 0x24 -> two acks, with the second acceptance exactly 3 cycles after the first; read returns 0xDEADBEEF.
REQ-037 Abort: cyc dropped during RD2 of a read of 0x28 -> no ack, FSM returns to IDLE; a following write completes normally with ack at +2.
REQ-038 Reset in WR: assert sys_rst asynchronously -> csr_we=0 and wb_ack_o=0 immediately, all outputs 0, no ack after release.
REQ-039 Address masking: adr=0xFFFF_0407 read -> csr_a=0x101; bits [31:16] and [1:0] have no effect.
